// File: rtl/spi_slave_ctrl_if.sv
// SPI mode-0 slave holding control register 0: deserialises 32-bit MSB-first frames
// from the CPU, commits them to ctrl_reg0 and shifts a status snapshot out on MISO.
module spi_slave_ctrl_if #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CTRL_RESET  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_ssb,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [31:0] status_in,
    output logic [31:0] ctrl_reg0,
    output logic        ctrl_wr_pulse,
    output logic        afe_start_pulse,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // SSB chain resets low so a select already asserted when reset releases
    // produces no falling edge; a high pin only yields a rise, ignored in IDLE.
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ssb_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   ssb_prev_q;
    logic                   mosi_prev_q;
    logic                   sclk_rise_q;
    logic                   sclk_fall_q;
    logic                   ssb_rise_q;
    logic                   ssb_fall_q;
    logic                   sclk_s;
    logic                   ssb_s;
    logic                   mosi_s;

    state_t      state_q,   state_d;
    logic [31:0] tx_sr_q,   tx_sr_d;
    logic [31:0] rx_sr_q,   rx_sr_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        miso_q,    miso_d;
    logic [31:0] ctrl_q,    ctrl_d;
    logic        wr_q,      wr_d;
    logic        afe_q,     afe_d;
    logic        err_q,     err_d;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ssb_s  = ssb_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ssb_sync_q  <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            ssb_prev_q  <= 1'b0;
            mosi_prev_q <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ssb_rise_q  <= 1'b0;
            ssb_fall_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            ssb_sync_q  <= {ssb_sync_q[SYNC_STAGES-2:0], spi_ssb};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            ssb_prev_q  <= ssb_s;
            mosi_prev_q <= mosi_s;
            // Registered strobes line up with mosi_prev_q, the bit sampled with them.
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            sclk_fall_q <= ~sclk_s & sclk_prev_q;
            ssb_rise_q  <= ssb_s & ~ssb_prev_q;
            ssb_fall_q  <= ~ssb_s & ssb_prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
            miso_q    <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            wr_q      <= 1'b0;
            afe_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
            miso_q    <= miso_d;
            ctrl_q    <= ctrl_d;
            wr_q      <= wr_d;
            afe_q     <= afe_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;
        miso_d    = miso_q;
        ctrl_d    = ctrl_q;
        wr_d      = 1'b0;
        afe_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ssb_fall_q) begin
                    state_d   = SHIFT;
                    tx_sr_d   = status_in;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    miso_d    = status_in[31];
                end
            end
            SHIFT: begin
                // SCLK work happens before the SSB check so a coincident last edge counts.
                if (sclk_rise_q) begin
                    rx_sr_d = {rx_sr_q[30:0], mosi_prev_q};
                    if (bit_cnt_q != 6'd33) begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                if (sclk_fall_q) begin
                    tx_sr_d = {tx_sr_q[30:0], 1'b0};
                    miso_d  = tx_sr_q[30];
                end
                if (ssb_rise_q) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (bit_cnt_q == 6'd32) begin
                    ctrl_d = rx_sr_q;
                    wr_d   = 1'b1;
                    afe_d  = rx_sr_q[31] & ~ctrl_q[31];
                end else begin
                    err_d = 1'b1;
                end
                miso_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    assign spi_miso        = miso_q;
    assign ctrl_reg0       = ctrl_q;
    assign ctrl_wr_pulse   = wr_q;
    assign afe_start_pulse = afe_q;
    assign frame_err       = err_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl_if.sv
// Directed bench for spi_slave_ctrl_if: 100 MHz clk, 10 MHz mode-0 SPI master model,
// immediate assertions against hand-computed expected values.
module tb_spi_slave_ctrl_if;

    localparam logic [31:0] RST_VAL = 32'h0000_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_ssb = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] status_in = 32'h0;
    logic [31:0] ctrl_reg0;
    logic        ctrl_wr_pulse;
    logic        afe_start_pulse;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0, afe_cnt = 0, err_cnt = 0;
    int wr_base, afe_base, err_base;
    logic [31:0] rx_word;

    spi_slave_ctrl_if #(.SYNC_STAGES(2), .CTRL_RESET(RST_VAL)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_ssb(spi_ssb), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .status_in(status_in), .ctrl_reg0(ctrl_reg0),
        .ctrl_wr_pulse(ctrl_wr_pulse), .afe_start_pulse(afe_start_pulse),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pulse high-cycle counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (ctrl_wr_pulse)   wr_cnt  <= wr_cnt + 1;
        if (afe_start_pulse) afe_cnt <= afe_cnt + 1;
        if (frame_err)       err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic frame_start();
        @(posedge clk);
        #2;
        wr_base  = wr_cnt;
        afe_base = afe_cnt;
        err_base = err_cnt;
        spi_ssb  = 1'b0;
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        #50 spi_sclk = 1'b1;
        #25 m = spi_miso;
        #25 spi_sclk = 1'b0;
    endtask

    task automatic frame_end();
        spi_mosi = 1'b0;
        #50 spi_ssb = 1'b1;
        #300;
    endtask

    task automatic run_frame(input logic [63:0] data, input int nbits, input int chg_at,
                             output logic [31:0] word);
        logic m;
        word = '0;
        frame_start();
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) status_in = 32'hFFFF_FFFF;
            send_bit(data[nbits-1-i], m);
            if (i < 32) word = {word[30:0], m};
            if (i == 0) check("busy_in_frame", {31'b0, busy}, 32'h1);
        end
        frame_end();
    endtask

    task automatic check_counts(input string tag, input int wr, input int afe, input int err);
        check({tag, "_wr"},  wr_cnt - wr_base,   wr);
        check({tag, "_afe"}, afe_cnt - afe_base, afe);
        check({tag, "_err"}, err_cnt - err_base, err);
    endtask

    initial begin
        logic m;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_ctrl", ctrl_reg0, RST_VAL);
        check("rst_outs", {27'b0, spi_miso, ctrl_wr_pulse, afe_start_pulse, frame_err, busy}, 32'h0);
        repeat (10) @(posedge clk);
        #2 check("idle_busy", {31'b0, busy}, 32'h0);

        run_frame(64'h0006_0001, 32, -1, rx_word);
        check("w1_ctrl", ctrl_reg0, 32'h0006_0001);
        check_counts("w1", 1, 0, 0);
        check("w1_busy_after", {31'b0, busy}, 32'h0);
        check("w1_miso_idle", {31'b0, spi_miso}, 32'h0);

        run_frame(64'h8010_0140, 32, -1, rx_word);
        check("afe1_ctrl", ctrl_reg0, 32'h8010_0140);
        check_counts("afe1", 1, 1, 0);
        run_frame(64'h8010_0140, 32, -1, rx_word);
        check("afe2_ctrl", ctrl_reg0, 32'h8010_0140);
        check_counts("afe2", 1, 0, 0);
        run_frame(64'h0010_0140, 32, -1, rx_word);
        check("afe3_ctrl", ctrl_reg0, 32'h0010_0140);
        check_counts("afe3", 1, 0, 0);
        run_frame(64'h8010_0140, 32, -1, rx_word);
        check("afe4_ctrl", ctrl_reg0, 32'h8010_0140);
        check_counts("afe4", 1, 1, 0);

        status_in = 32'hA5A5_1234;
        run_frame(64'h0, 32, -1, rx_word);
        check("rd_miso", rx_word, 32'hA5A5_1234);
        check("rd_ctrl", ctrl_reg0, 32'h0);
        check_counts("rd", 1, 0, 0);

        status_in = 32'h3C3C_C3C3;
        run_frame(64'h0000_1111, 32, 8, rx_word);
        check("stchg_miso", rx_word, 32'h3C3C_C3C3);
        check("stchg_ctrl", ctrl_reg0, 32'h0000_1111);
        check_counts("stchg", 1, 0, 0);

        run_frame(64'hFFFF, 16, -1, rx_word);
        check("len16_ctrl", ctrl_reg0, 32'h0000_1111);
        check_counts("len16", 0, 0, 1);
        run_frame(64'h3_FFFF_FFFF, 34, -1, rx_word);
        check("len34_ctrl", ctrl_reg0, 32'h0000_1111);
        check_counts("len34", 0, 0, 1);

        status_in = 32'hFFFF_FFFF;
        frame_start();
        for (int i = 0; i < 10; i++) send_bit(1'b1, m);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        check("mrst_ctrl", ctrl_reg0, RST_VAL);
        check("mrst_outs", {27'b0, spi_miso, ctrl_wr_pulse, afe_start_pulse, frame_err, busy}, 32'h0);
        for (int i = 0; i < 22; i++) begin
            send_bit(1'b1, m);
            check("mrst_miso_ignored", {31'b0, m}, 32'h0);
        end
        frame_end();
        check("mrst_tail_ctrl", ctrl_reg0, RST_VAL);
        check_counts("mrst_tail", 0, 0, 0);
        check("mrst_tail_busy", {31'b0, busy}, 32'h0);

        run_frame(64'h1234_5678, 32, -1, rx_word);
        check("post_ctrl", ctrl_reg0, 32'h1234_5678);
        check_counts("post", 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
